gpio_pad_ctrl: RTL and testbench
================================

GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 SHALL have parameter NumPads, default 32, number of GPIO pads, legal range 1..32.
REQ-002 SHALL have parameter FilterLen, default 4, glitch-filter stable-cycle count, legal range 1..255.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have ports req_i in 1, we_i in 1, addr_i in 6, wdata_i in 32: register request, byte address, word aligned.
REQ-007 SHALL have ports rvalid_o out 1, rdata_o out 32, err_o out 1: register response.
REQ-008 SHALL have port pad_c_i  in  NumPads  raw pad input (C), asynchronous.
REQ-009 SHALL have ports pad_i_o, pad_oe_o, pad_ie_o, pad_od_o, pad_pu_o, pad_pd_o, pad_ds0_o, pad_ds1_o, each out NumPads: per-pad PBMUX controls.
REQ-010 SHALL have port irq_o  out  1  level interrupt.

Function
REQ-011 SHALL decode this register map (bits >= NumPads read 0, writes ignored): 0x00 OUT, 0x04 OE, 0x08 IN (RO), 0x0C RISE_EN, 0x10 FALL_EN, 0x14 STATUS (W1C), 0x18 OD, 0x1C PU, 0x20 PD, 0x24 DS0, 0x28 DS1.
REQ-012 SHALL assert rvalid_o exactly one cycle after any accepted req_i, with rdata_o valid in that cycle and 0 otherwise.
REQ-013 SHALL accept a request every cycle; back-to-back requests produce back-to-back responses.
REQ-014 SHALL, for address >= 0x2C or misaligned, ignore the write, return rdata_o=0 and assert err_o with rvalid_o.
REQ-015 SHALL ignore writes to IN without error.
REQ-016 SHALL drive pad_ie_o = ~pad_oe_o per pad.
REQ-017 SHALL, for OD=0, drive pad_i_o = OUT and pad_oe_o = OE.
REQ-018 SHALL, for OD=1, drive pad_i_o = 0 and pad_oe_o = OE & ~OUT (open drain: drive low or release).
REQ-019 SHALL drive pad_pu_o, pad_pd_o, pad_ds0_o, pad_ds1_o from PU, PD, DS0, DS1 combinationally from the registers.
REQ-020 SHALL pass pad_c_i through a 2-flop synchronizer per pad.
REQ-021 SHALL run one glitch filter per pad: counter cleared while sync == filt; otherwise it increments, and when it reaches FilterLen-1 with sync != filt still true, filt <= sync and counter <= 0.
REQ-022 SHALL make IN = filt; a clean pad edge reaches IN 2+FilterLen cycles later; pulses shorter than FilterLen cycles after sync are never seen on IN.
REQ-023 SHALL set STATUS[n] on a filt 0->1 transition when RISE_EN[n]=1, and on a 1->0 transition when FALL_EN[n]=1.
REQ-024 SHALL clear STATUS bits on a write of 1 to them; a set and a W1C in the same cycle SHALL leave the bit set.
REQ-025 SHALL not retro-set STATUS when an enable is written while filt is already stable.
REQ-026 SHALL drive irq_o = |STATUS, registered; it follows STATUS in the same cycle as the flop.

Reset
REQ-027 SHALL, on rst_i high at a clock edge, clear OUT, OE, OD, PU, PD, DS1, RISE_EN, FALL_EN, STATUS, sync flops, filt and counters to 0, set DS0 to all-ones, and clear rvalid_o, err_o, irq_o.
REQ-028 SHALL drop any in-flight response when rst_i is asserted mid-operation; no rvalid_o follows.
REQ-029 SHALL, after reset, drive pad_oe_o=0, pad_ie_o=all-ones, pad_ds0_o=all-ones, and all other pad outputs 0.

Verification
REQ-030 SHALL cover: reset, then read every register -> values per REQ-027; read 0x30 -> err_o=1, rdata_o=0.
REQ-031 SHALL cover: OE=0x1, OUT=0x1, OD=0 -> pad_i_o[0]=1, pad_oe_o[0]=1, pad_ie_o[0]=0; then OD=0x1 -> pad_oe_o[0]=0; then OUT=0 -> pad_oe_o[0]=1, pad_i_o[0]=0.
REQ-032 SHALL cover, with FilterLen=4: pad_c_i[3] rising step -> IN[3]=1 exactly 6 cycles later; a 3-cycle high pulse -> IN[3] stays 0.
REQ-033 SHALL cover: RISE_EN=0x8, rising edge on pad 3 -> STATUS=0x8, irq_o=1; write STATUS=0x8 -> STATUS=0, irq_o=0; W1C in the same cycle as a new edge -> bit stays 1.
REQ-034 SHALL cover: FALL_EN=0x1, pad 0 falls, rst_i asserted during filter count -> STATUS=0, IN=0, no irq_o after release.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: register file, per-pad output/pull/drive controls,
// synchronized and glitch-filtered inputs, and edge-triggered interrupt status.
module gpio_pad_ctrl #(
    parameter int NumPads   = 32,
    parameter int FilterLen = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [5:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic               err_o,
    input  logic [NumPads-1:0] pad_c_i,
    output logic [NumPads-1:0] pad_i_o,
    output logic [NumPads-1:0] pad_oe_o,
    output logic [NumPads-1:0] pad_ie_o,
    output logic [NumPads-1:0] pad_od_o,
    output logic [NumPads-1:0] pad_pu_o,
    output logic [NumPads-1:0] pad_pd_o,
    output logic [NumPads-1:0] pad_ds0_o,
    output logic [NumPads-1:0] pad_ds1_o,
    output logic               irq_o
);

    typedef enum logic [3:0] {
        R_OUT    = 4'd0,
        R_OE     = 4'd1,
        R_IN     = 4'd2,
        R_RISE   = 4'd3,
        R_FALL   = 4'd4,
        R_STATUS = 4'd5,
        R_OD     = 4'd6,
        R_PU     = 4'd7,
        R_PD     = 4'd8,
        R_DS0    = 4'd9,
        R_DS1    = 4'd10
    } reg_e;

    localparam logic [7:0] CntMax = 8'(FilterLen - 1);

    logic [NumPads-1:0] out_q, oe_q, od_q, pu_q, pd_q, ds0_q, ds1_q;
    logic [NumPads-1:0] rise_en_q, fall_en_q, status_q, status_d;
    logic [NumPads-1:0] sync1_q, sync2_q, filt_q, flip, set_evt, w1c;
    logic [7:0]         cnt_q [NumPads];
    logic [NumPads-1:0] wd;
    logic [31:0]        rd_word;
    logic [31:0]        rdata_q;
    logic               rvalid_q, err_q, irq_q;
    logic               addr_err, wr_en;
    reg_e               word;

    assign word     = reg_e'(addr_i[5:2]);
    assign addr_err = (addr_i[1:0] != 2'b00) || (addr_i >= 6'h2C);
    assign wr_en    = req_i && we_i && !addr_err;
    assign wd       = wdata_i[NumPads-1:0];

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_word = '0;
        case (word)
            R_OUT:    rd_word = 32'(out_q);
            R_OE:     rd_word = 32'(oe_q);
            R_IN:     rd_word = 32'(filt_q);
            R_RISE:   rd_word = 32'(rise_en_q);
            R_FALL:   rd_word = 32'(fall_en_q);
            R_STATUS: rd_word = 32'(status_q);
            R_OD:     rd_word = 32'(od_q);
            R_PU:     rd_word = 32'(pu_q);
            R_PD:     rd_word = 32'(pd_q);
            R_DS0:    rd_word = 32'(ds0_q);
            R_DS1:    rd_word = 32'(ds1_q);
            default:  rd_word = '0;
        endcase
    end

    // A pad's filtered value flips on the cycle its counter expires with sync still differing.
    always_comb begin
        flip = '0;
        for (int i = 0; i < NumPads; i++) begin
            flip[i] = (sync2_q[i] != filt_q[i]) && (cnt_q[i] == CntMax);
        end
    end

    assign set_evt  = (flip & sync2_q & rise_en_q) | (flip & ~sync2_q & fall_en_q);
    assign w1c      = (wr_en && word == R_STATUS) ? wd : '0;
    // Set wins over a simultaneous write-one-to-clear.
    assign status_d = (status_q & ~w1c) | set_evt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q     <= '0;
            oe_q      <= '0;
            od_q      <= '0;
            pu_q      <= '0;
            pd_q      <= '0;
            ds0_q     <= '1;
            ds1_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < NumPads; i++) cnt_q[i] <= '0;
        end else begin
            if (wr_en) begin
                case (word)
                    R_OUT:   out_q     <= wd;
                    R_OE:    oe_q      <= wd;
                    R_RISE:  rise_en_q <= wd;
                    R_FALL:  fall_en_q <= wd;
                    R_OD:    od_q      <= wd;
                    R_PU:    pu_q      <= wd;
                    R_PD:    pd_q      <= wd;
                    R_DS0:   ds0_q     <= wd;
                    R_DS1:   ds1_q     <= wd;
                    default: ;
                endcase
            end
            status_q <= status_d;
            irq_q    <= |status_d;
            rvalid_q <= req_i;
            err_q    <= req_i && addr_err;
            rdata_q  <= (req_i && !addr_err) ? rd_word : '0;
            sync1_q  <= pad_c_i;
            sync2_q  <= sync1_q;
            for (int i = 0; i < NumPads; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (flip[i]) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign irq_o     = irq_q;

    // Open drain: never drive high, enable the driver only to pull low.
    assign pad_i_o   = out_q & ~od_q;
    assign pad_oe_o  = oe_q & ~(od_q & out_q);
    assign pad_ie_o  = ~pad_oe_o;
    assign pad_od_o  = od_q;
    assign pad_pu_o  = pu_q;
    assign pad_pd_o  = pd_q;
    assign pad_ds0_o = ds0_q;
    assign pad_ds1_o = ds1_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed self-checking bench for gpio_pad_ctrl (NumPads=32, FilterLen=4).
module tb_gpio_pad_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [5:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rvalid_o, err_o, irq_o;
    logic [31:0] rdata_o;
    logic [31:0] pad_c_i = '0;
    logic [31:0] pad_i_o, pad_oe_o, pad_ie_o, pad_od_o;
    logic [31:0] pad_pu_o, pad_pd_o, pad_ds0_o, pad_ds1_o;

    int vectors = 0;
    int miscompares = 0;

    gpio_pad_ctrl #(.NumPads(32), .FilterLen(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .pad_c_i(pad_c_i),
        .pad_i_o(pad_i_o), .pad_oe_o(pad_oe_o), .pad_ie_o(pad_ie_o),
        .pad_od_o(pad_od_o), .pad_pu_o(pad_pu_o), .pad_pd_o(pad_pd_o),
        .pad_ds0_o(pad_ds0_o), .pad_ds1_o(pad_ds1_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [5:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e);
        req_i   = 1'b1;
        we_i    = w;
        addr_i  = a;
        wdata_i = d;
        tick();
        req_i   = 1'b0;
        we_i    = 1'b0;
        check($sformatf("rvalid@%h", a), 32'(rvalid_o), 32'd1);
        rd = rdata_o;
        e  = err_o;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        e;
        bus(1'b1, a, d, rd, e);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e;
        bus(1'b0, a, '0, rd, e);
        check(tag, rd, exp);
        check({tag, "_err"}, 32'(e), 32'd0);
    endtask

    localparam logic [5:0] A_OUT = 6'h00, A_OE = 6'h04, A_IN = 6'h08, A_RISE = 6'h0C,
                           A_FALL = 6'h10, A_STATUS = 6'h14, A_OD = 6'h18, A_PU = 6'h1C,
                           A_PD = 6'h20, A_DS0 = 6'h24, A_DS1 = 6'h28;

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [31:0] rst_vals [11];
        rst_vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};

        // Reset state of pads and every register.
        tick(2);
        rst_i = 1'b0;
        check("rst_oe", pad_oe_o, 32'h0);
        check("rst_ie", pad_ie_o, 32'hFFFF_FFFF);
        check("rst_ds0", pad_ds0_o, 32'hFFFF_FFFF);
        check("rst_i", pad_i_o, 32'h0);
        check("rst_pu", pad_pu_o, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        for (int r = 0; r < 11; r++) begin
            rd_chk($sformatf("rst_reg%0d", r), 6'(r * 4), rst_vals[r]);
        end

        // Error responses: out of range and misaligned.
        bus(1'b0, 6'h30, '0, rd, e);
        check("oor_data", rd, 32'h0);
        check("oor_err", 32'(e), 32'd1);
        bus(1'b1, 6'h02, 32'hFFFF_FFFF, rd, e);
        check("misal_err", 32'(e), 32'd1);
        rd_chk("misal_nowrite", A_OUT, 32'h0);
        tick();
        check("idle_rvalid", 32'(rvalid_o), 32'd0);
        check("idle_rdata", rdata_o, 32'h0);

        // Writes to IN are ignored without error.
        bus(1'b1, A_IN, 32'hFFFF_FFFF, rd, e);
        check("in_wr_err", 32'(e), 32'd0);
        rd_chk("in_ro", A_IN, 32'h0);

        // Push-pull and open-drain behaviour on pad 0.
        wr(A_OE, 32'h1);
        wr(A_OUT, 32'h1);
        wr(A_OD, 32'h0);
        check("pp_i", 32'(pad_i_o[0]), 32'd1);
        check("pp_oe", 32'(pad_oe_o[0]), 32'd1);
        check("pp_ie", 32'(pad_ie_o[0]), 32'd0);
        wr(A_OD, 32'h1);
        check("od_hi_oe", 32'(pad_oe_o[0]), 32'd0);
        check("od_hi_i", 32'(pad_i_o[0]), 32'd0);
        check("od_hi_ie", 32'(pad_ie_o[0]), 32'd1);
        wr(A_OUT, 32'h0);
        check("od_lo_oe", 32'(pad_oe_o[0]), 32'd1);
        check("od_lo_i", 32'(pad_i_o[0]), 32'd0);
        wr(A_OD, 32'h0);
        wr(A_OE, 32'h0);

        // Pull and drive-strength passthrough.
        wr(A_PU, 32'hA5A5_0001);
        wr(A_PD, 32'h0F0F_0000);
        wr(A_DS0, 32'h1234_5678);
        wr(A_DS1, 32'h8000_0003);
        check("pu", pad_pu_o, 32'hA5A5_0001);
        check("pd", pad_pd_o, 32'h0F0F_0000);
        check("ds0", pad_ds0_o, 32'h1234_5678);
        check("ds1", pad_ds1_o, 32'h8000_0003);
        rd_chk("ds1_rd", A_DS1, 32'h8000_0003);

        // Clean rising step on pad 3 lands on IN exactly six edges later.
        pad_c_i[3] = 1'b1;
        tick(5);
        rd_chk("in_edge5", A_IN, 32'h0);
        rd_chk("in_edge6", A_IN, 32'h8);
        check("no_status", 32'(irq_o), 32'd0);
        pad_c_i[3] = 1'b0;
        tick(10);
        rd_chk("in_fell", A_IN, 32'h0);

        // A three-cycle glitch is filtered out.
        pad_c_i[3] = 1'b1;
        tick(3);
        pad_c_i[3] = 1'b0;
        tick(10);
        rd_chk("glitch", A_IN, 32'h0);

        // Rising-edge interrupt and write-one-to-clear.
        wr(A_RISE, 32'h8);
        pad_c_i[3] = 1'b1;
        tick(8);
        rd_chk("rise_status", A_STATUS, 32'h8);
        check("rise_irq", 32'(irq_o), 32'd1);
        wr(A_STATUS, 32'h8);
        check("w1c_irq", 32'(irq_o), 32'd0);
        rd_chk("w1c_status", A_STATUS, 32'h0);

        // Enabling falls on an already-stable pad must not set status.
        wr(A_FALL, 32'h8);
        tick(3);
        rd_chk("no_retro", A_STATUS, 32'h0);

        // W1C landing on the same edge as a new fall leaves the bit set.
        pad_c_i[3] = 1'b0;
        tick(5);
        wr(A_STATUS, 32'h8);
        check("race_irq", 32'(irq_o), 32'd1);
        rd_chk("race_status", A_STATUS, 32'h8);
        wr(A_STATUS, 32'h8);
        rd_chk("race_clr", A_STATUS, 32'h0);
        wr(A_RISE, 32'h0);
        wr(A_FALL, 32'h0);

        // Reset in the middle of a fall count on pad 0, with a request in flight.
        pad_c_i[0] = 1'b1;
        tick(8);
        rd_chk("pad0_hi", A_IN, 32'h1);
        wr(A_FALL, 32'h1);
        pad_c_i[0] = 1'b0;
        tick(3);
        rst_i  = 1'b1;
        req_i  = 1'b1;
        addr_i = A_IN;
        tick();
        req_i  = 1'b0;
        check("rst_drop_rvalid", 32'(rvalid_o), 32'd0);
        rst_i = 1'b0;
        tick(10);
        check("rst_mid_irq", 32'(irq_o), 32'd0);
        rd_chk("rst_mid_status", A_STATUS, 32'h0);
        rd_chk("rst_mid_in", A_IN, 32'h0);
        rd_chk("rst_mid_fall", A_FALL, 32'h0);
        check("rst_mid_ds0", pad_ds0_o, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
